ysyx_23060075_gpr_sb: RTL and testbench

//  Parametrised general-purpose register file with NR_RD read ports, one write-back port and a
//  per-register busy scoreboard. Decode/issue allocates destinations; write-back fills data and

---
 rtl/ysyx_23060075_gpr_sb.sv | 79 +++++++
 tb/tb_ysyx_23060075_gpr_sb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060075_gpr_sb.sv
// GPR file with NR_RD combinational read ports, one write-back port and a per-register busy scoreboard.
// Latency: reads 0 cycles; writes and scoreboard updates on the next rising edge. Option: YSYX_23060075_GPR_BYPASS_EN.
// Backpressure: alloc_ready drops while the destination is busy and not being written back (WAW stall).
module ysyx_23060075_gpr_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NR_RD      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NR_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NR_RD-1:0]            rd_busy,
    input  logic                        alloc_valid,
    input  logic [ADDR_WIDTH-1:0]       alloc_addr,
    output logic                        alloc_ready,
    input  logic                        wb_en,
    input  logic [ADDR_WIDTH-1:0]       wb_addr,
    input  logic [DATA_WIDTH-1:0]       wb_data,
    output logic                        busy_any
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wb_fire;
    logic                  alloc_fire;

    // Gating with rst keeps outputs at their reset values while inputs are ignored.
    assign wb_fire     = rst && wb_en && (wb_addr != '0);
    assign alloc_ready = !rst || (alloc_addr == '0) || !busy[alloc_addr] ||
                         (wb_fire && (wb_addr == alloc_addr));
    assign alloc_fire  = rst && alloc_valid && alloc_ready && (alloc_addr != '0);
    assign busy_any    = |busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_fire) begin
                mem[wb_addr]  <= wb_data;
                busy[wb_addr] <= 1'b0;
            end
            // A new producer supersedes the one writing back in the same cycle.
            if (alloc_fire) begin
                busy[alloc_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] d;
        logic                  b;

        assign a = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            d = mem[a];
            b = busy[a];
`ifdef YSYX_23060075_GPR_BYPASS_EN
            if (wb_fire && (wb_addr == a)) begin
                d = wb_data;
                b = 1'b0;
            end
`endif
            if (a == '0) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
        assign rd_busy[i]                          = b;
    end
endmodule

// File: tb/tb_ysyx_23060075_gpr_sb.sv
// Bench for ysyx_23060075_gpr_sb: vector table, hand-written hazard sequences and a randomised reference model.
module tb_ysyx_23060075_gpr_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic          clk;
    logic          rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0] rd_busy;
    logic          alloc_valid;
    logic [AW-1:0] alloc_addr;
    logic          alloc_ready;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          busy_any;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_23060075_gpr_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_RD(NR)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy_any(busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          av;
        logic [AW-1:0] aa;
        logic [AW-1:0] ra;
        logic [DW-1:0] ed;
        logic          eb;
        logic          er;
        logic          ea;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_rd(input logic [AW-1:0] a);
        for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = a;
    endtask

    task automatic idle();
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        alloc_valid = 1'b0; alloc_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] port(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    logic [DW-1:0] rm [32];
    logic [31:0]   rb;
    logic [DW-1:0] ed;
    logic          eb;
    logic          er;
    logic          hold;
    logic [AW-1:0] a;

    initial begin
        rst = 1'b0;
        idle();
        set_rd('0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        //          we    wa   wd            av    aa   ra   ed            eb    er    ea
        tv[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b0};
        tv[1]  = '{1'b1, 5'd5, 32'h1234,     1'b0, 5'd0, 5'd1, 32'h0,      1'b0, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd5, 32'h1234,   1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 32'h1234,   1'b1, 1'b1, 1'b1};
        tv[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1};
        tv[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,      1'b0, 1'b1, 1'b1};
        tv[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd5, 32'h1234,   1'b1, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 5'd5, 32'h5555,     1'b1, 5'd5, 5'd2, 32'h0,      1'b0, 1'b1, 1'b1};
        tv[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 32'h5555,   1'b1, 1'b1, 1'b1};
        tv[9]  = '{1'b1, 5'd5, 32'h7777,     1'b0, 5'd0, 5'd3, 32'h0,      1'b0, 1'b1, 1'b1};
        tv[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 32'h7777,   1'b0, 1'b1, 1'b0};
`ifdef YSYX_23060075_GPR_BYPASS_EN
        tv[11] = '{1'b1, 5'd6, 32'hABCD,     1'b0, 5'd0, 5'd6, 32'hABCD,   1'b0, 1'b1, 1'b0};
`else
        tv[11] = '{1'b1, 5'd6, 32'hABCD,     1'b0, 5'd0, 5'd6, 32'h0,      1'b0, 1'b1, 1'b0};
`endif
        tv[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd6, 32'hABCD,   1'b0, 1'b1, 1'b0};

        for (int v = 0; v < 13; v++) begin
            wb_en = tv[v].we; wb_addr = tv[v].wa; wb_data = tv[v].wd;
            alloc_valid = tv[v].av; alloc_addr = tv[v].aa;
            set_rd(tv[v].ra);
            #1;
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("vec%0d rd_data[%0d]", v, i), port(i), tv[v].ed);
                chk($sformatf("vec%0d rd_busy[%0d]", v, i), {31'b0, rd_busy[i]}, {31'b0, tv[v].eb});
            end
            chk($sformatf("vec%0d alloc_ready", v), {31'b0, alloc_ready}, {31'b0, tv[v].er});
            chk($sformatf("vec%0d busy_any", v), {31'b0, busy_any}, {31'b0, tv[v].ea});
            step();
        end

        // RAW on r3
        idle(); alloc_valid = 1'b1; alloc_addr = 5'd3; step();
        idle(); set_rd(5'd3); #1;
        chk("raw busy after alloc", {31'b0, rd_busy[0]}, 32'd1);
        chk("raw busy_any", {31'b0, busy_any}, 32'd1);
        step();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD; #1;
`ifdef YSYX_23060075_GPR_BYPASS_EN
        chk("raw bypass data", port(0), 32'hDEAD);
        chk("raw bypass busy", {31'b0, rd_busy[0]}, 32'd0);
`else
        chk("raw wb-cycle data", port(0), 32'h0);
        chk("raw wb-cycle busy", {31'b0, rd_busy[0]}, 32'd1);
`endif
        step();
        idle(); #1;
        chk("raw data after wb", port(0), 32'hDEAD);
        chk("raw busy after wb", {31'b0, rd_busy[0]}, 32'd0);
        chk("raw busy_any after wb", {31'b0, busy_any}, 32'd0);

        // WAW stall on r7
        alloc_valid = 1'b1; alloc_addr = 5'd7; step();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("waw stall cycle %0d", c), {31'b0, alloc_ready}, 32'd0);
            step();
        end
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77; #1;
        chk("waw ready on wb", {31'b0, alloc_ready}, 32'd1);
        step();
        idle(); set_rd(5'd7); #1;
        chk("waw busy after", {31'b0, rd_busy[1]}, 32'd1);
        chk("waw data after", port(1), 32'h77);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77; step();

        // Simultaneous alloc and wb on r9
        idle(); alloc_valid = 1'b1; alloc_addr = 5'd9; step();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99; step();
        idle(); set_rd(5'd9); #1;
        chk("sim busy stays", {31'b0, rd_busy[2]}, 32'd1);
        chk("sim data", port(2), 32'h99);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99; step();

        // Multiport on r12
        idle(); wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hA5A5A5A5; step();
        idle(); set_rd(5'd12); #1;
        for (int i = 0; i < NR; i++)
            chk($sformatf("multiport rd_data[%0d]", i), port(i), 32'hA5A5A5A5);

        // Mid-run reset with r5 written and busy
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        alloc_valid = 1'b1; alloc_addr = 5'd5; step();
        idle(); set_rd(5'd5); #1;
        chk("pre-reset busy", {31'b0, rd_busy[0]}, 32'd1);
        rst = 1'b0; alloc_valid = 1'b1; alloc_addr = 5'd5; #1;
        chk("reset rd_data", port(0), 32'h0);
        chk("reset rd_busy", {31'b0, rd_busy[0]}, 32'd0);
        chk("reset busy_any", {31'b0, busy_any}, 32'd0);
        chk("reset alloc_ready", {31'b0, alloc_ready}, 32'd1);
        step();
        rst = 1'b1; idle(); #1;
        chk("post-reset rd_data", port(0), 32'h0);

        // Random traffic against the reference model, starting from reset
        for (int k = 0; k < 32; k++) rm[k] = '0;
        rb = '0;
        hold = 1'b0;
        step();
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                alloc_valid = 1'($urandom_range(0, 1));
                alloc_addr  = AW'($urandom_range(0, 15));
            end
            wb_en   = 1'($urandom_range(0, 1));
            wb_addr = AW'($urandom_range(0, 15));
            wb_data = $urandom;
            for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
            #1;
            er = (alloc_addr == 0) || !rb[alloc_addr] || (wb_en && wb_addr == alloc_addr);
            chk("rand alloc_ready", {31'b0, alloc_ready}, {31'b0, er});
            chk("rand busy_any", {31'b0, busy_any}, {31'b0, |rb});
            for (int i = 0; i < NR; i++) begin
                a  = rd_addr[i*AW +: AW];
                ed = (a == 0) ? '0 : rm[a];
                eb = (a == 0) ? 1'b0 : rb[a];
`ifdef YSYX_23060075_GPR_BYPASS_EN
                if (wb_en && wb_addr != 0 && wb_addr == a) begin
                    ed = wb_data;
                    eb = 1'b0;
                end
`endif
                chk("rand rd_data", port(i), ed);
                chk("rand rd_busy", {31'b0, rd_busy[i]}, {31'b0, eb});
            end
            @(posedge clk);
            if (wb_en && wb_addr != 0) begin
                rm[wb_addr] = wb_data;
                rb[wb_addr] = 1'b0;
            end
            if (alloc_valid && er && alloc_addr != 0) rb[alloc_addr] = 1'b1;
            hold = alloc_valid && !er;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
